miss_replay_queue: RTL and testbench

MISS_REPLAY_QUEUE -- requirements
Module: miss_replay_queue

---
 rtl/miss_replay_queue.sv | 143 ++++++++++++++
 tb/tb_miss_replay_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/miss_replay_queue.sv
// Miss replay queue: records cache-miss addresses in arrival order and replays
// the recorded list on request through a valid/ready output stream.
module miss_replay_queue #(
  parameter int ADDR_W        = 10,
  parameter int DEPTH         = 256,
  parameter int DEDUP         = 1,
  parameter int CLR_ON_REPLAY = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  input  logic [ADDR_W-1:0]        miss_addr,
  output logic                     miss_ready,
  input  logic                     replay_start,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, REPLAY} state_t;

  state_t            state, state_d;
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] last_addr;
  logic [CW-1:0]     rd_idx;
  logic [CW-1:0]     replay_len;
  logic [CW-1:0]     count_after_push;
  logic              push, dup, store, ovf_set;
  logic              start, load, finish;

  // Assertion reaches every flop at once; release waits two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign miss_ready       = (state == IDLE) && (count < FULL);
  assign busy             = (state == REPLAY);
  assign push             = miss_valid && miss_ready && !clear;
  assign dup              = (DEDUP != 0) && (count != '0) && (miss_addr == last_addr);
  assign store            = push && !dup;
  assign ovf_set          = miss_valid && (state == IDLE) && (count == FULL) && !clear;
  assign count_after_push = count + CW'(store);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (replay_start && (count_after_push != '0)) begin
          start   = 1'b1;
          state_d = REPLAY;
        end
      end
      REPLAY: begin
        if (!out_valid) begin
          load = 1'b1;
        end else if (out_ready) begin
          if (rd_idx == replay_len) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      start   = 1'b0;
      load    = 1'b0;
      finish  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_d;
  end

  // NOTE: the storage array is deliberately not reset; count alone defines
  // which entries are meaningful, and resetting it would forbid RAM mapping.
  always_ff @(posedge clk) begin
    if (store) mem[count[IW-1:0]] <= miss_addr;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      count      <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      rd_idx     <= '0;
      replay_len <= '0;
      last_addr  <= '0;
    end else if (clear) begin
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (store) begin
        count     <= count_after_push;
        last_addr <= miss_addr;
      end
      if (ovf_set) overflow <= 1'b1;
      if (start) begin
        replay_len <= count_after_push;
        rd_idx     <= '0;
        out_valid  <= 1'b0;
      end
      // rd_idx < replay_len <= DEPTH whenever load is high, so the low bits
      // always form a valid array index.
      if (load) begin
        out_addr  <= mem[rd_idx[IW-1:0]];
        out_valid <= 1'b1;
        rd_idx    <= rd_idx + 1'b1;
      end
      if (finish) begin
        out_valid <= 1'b0;
        if (CLR_ON_REPLAY != 0) count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_miss_replay_queue.sv
// Directed bench for miss_replay_queue: a default instance and a DEPTH=4,
// CLR_ON_REPLAY=1 instance share one stimulus stream and are checked together.
module tb_miss_replay_queue;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              miss_valid, replay_start, clear, out_ready;
  logic [ADDR_W-1:0] miss_addr;

  logic              a_miss_ready, a_out_valid, a_busy, a_overflow;
  logic [ADDR_W-1:0] a_out_addr;
  logic [8:0]        a_count;
  logic              b_miss_ready, b_out_valid, b_busy, b_overflow;
  logic [ADDR_W-1:0] b_out_addr;
  logic [2:0]        b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  miss_replay_queue u_dut (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(a_miss_ready), .replay_start(replay_start), .clear(clear),
    .out_valid(a_out_valid), .out_addr(a_out_addr), .out_ready(out_ready),
    .busy(a_busy), .count(a_count), .overflow(a_overflow)
  );

  miss_replay_queue #(.DEPTH(4), .CLR_ON_REPLAY(1)) u_small (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(b_miss_ready), .replay_start(replay_start), .clear(clear),
    .out_valid(b_out_valid), .out_addr(b_out_addr), .out_ready(out_ready),
    .busy(b_busy), .count(b_count), .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] addr);
    miss_valid = 1'b1;
    miss_addr  = addr;
    step();
    miss_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic start_replay();
    replay_start = 1'b1;
    out_ready    = 1'b1;
    step();
    replay_start = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] seq4 [4];
    rst_n = 1'b0; miss_valid = 1'b0; miss_addr = '0;
    replay_start = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_count",    32'(a_count), 0);
    check("rst_valid",    32'(a_out_valid), 0);
    check("rst_addr",     32'(a_out_addr), 0);
    check("rst_busy",     32'(a_busy), 0);
    check("rst_ovf",      32'(a_overflow), 0);
    check("rst_ready",    32'(a_miss_ready), 1);
    check("rst_b_ready",  32'(b_miss_ready), 1);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Basic four-entry replay at full throughput.
    seq4 = '{10'h1ED, 10'h1F4, 10'h1C0, 10'h1CE};
    foreach (seq4[i]) push(seq4[i]);
    check("t1_count", 32'(a_count), 4);
    start_replay();
    check("t1_busy_n",  32'(a_busy), 1);
    check("t1_valid_n", 32'(a_out_valid), 0);
    foreach (seq4[i]) begin
      step();
      check("t1_a_valid", 32'(a_out_valid), 1);
      check("t1_a_addr",  32'(a_out_addr), 32'(seq4[i]));
      check("t1_b_addr",  32'(b_out_addr), 32'(seq4[i]));
    end
    step();
    check("t1_end_valid", 32'(a_out_valid), 0);
    check("t1_end_busy",  32'(a_busy), 0);
    check("t1_a_count",   32'(a_count), 4);
    check("t1_b_count",   32'(b_count), 0);
    do_clear();
    check("t1_clr_count", 32'(a_count), 0);

    // Consecutive duplicate misses collapse into one entry.
    push(10'h1ED); push(10'h1ED); push(10'h1F4);
    check("t2_a_count", 32'(a_count), 2);
    check("t2_b_count", 32'(b_count), 2);
    start_replay();
    check("t2_ready_busy", 32'(a_miss_ready), 0);
    step();
    check("t2_addr0", 32'(a_out_addr), 10'h1ED);
    step();
    check("t2_addr1", 32'(a_out_addr), 10'h1F4);
    step();
    check("t2_end_valid", 32'(a_out_valid), 0);
    do_clear();

    // Consumer stalls: ready pattern 1,0,0,1 after the first entry.
    push(10'h011); push(10'h022); push(10'h033);
    start_replay();
    step();
    check("t3_addr0", 32'(a_out_addr), 10'h011);
    step();
    check("t3_addr1", 32'(a_out_addr), 10'h022);
    out_ready = 1'b0;
    step();
    check("t3_stall1_addr",  32'(a_out_addr), 10'h022);
    check("t3_stall1_valid", 32'(a_out_valid), 1);
    step();
    check("t3_stall2_addr",  32'(b_out_addr), 10'h022);
    out_ready = 1'b1;
    step();
    check("t3_addr2", 32'(a_out_addr), 10'h033);
    step();
    check("t3_end_valid", 32'(a_out_valid), 0);
    check("t3_end_busy",  32'(b_busy), 0);
    do_clear();

    // Overflow on the small instance; the large one just keeps storing.
    for (int i = 1; i <= 4; i++) push(10'h100 + 10'(i));
    miss_valid = 1'b1;
    miss_addr  = 10'h105;
    check("t4_b_ready_full", 32'(b_miss_ready), 0);
    check("t4_a_ready",      32'(a_miss_ready), 1);
    step();
    miss_valid = 1'b0;
    check("t4_a_count", 32'(a_count), 5);
    check("t4_b_count", 32'(b_count), 4);
    check("t4_b_ovf",   32'(b_overflow), 1);
    check("t4_a_ovf",   32'(a_overflow), 0);
    step();
    check("t4_b_ovf_sticky", 32'(b_overflow), 1);
    do_clear();
    check("t4_b_ovf_clr",   32'(b_overflow), 0);
    check("t4_b_count_clr", 32'(b_count), 0);

    // Full-list replay on DEPTH=4; misses offered during replay are ignored.
    for (int i = 1; i <= 4; i++) push(10'h300 + 10'(i));
    start_replay();
    miss_valid = 1'b1;
    miss_addr  = 10'h3FF;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t5_b_valid", 32'(b_out_valid), 1);
      check("t5_b_addr",  32'(b_out_addr), 32'(10'h300 + 10'(i)));
      if (i == 3) miss_valid = 1'b0;
    end
    check("t5_a_ready_busy", 32'(a_miss_ready), 0);
    step();
    check("t5_b_end_valid", 32'(b_out_valid), 0);
    check("t5_b_ovf",       32'(b_overflow), 0);
    check("t5_b_count",     32'(b_count), 0);
    check("t5_a_count",     32'(a_count), 4);
    do_clear();

    // Start with empty list is ignored; same-cycle push makes it a 1-entry replay.
    replay_start = 1'b1;
    step();
    replay_start = 1'b0;
    check("t6_empty_busy", 32'(a_busy), 0);
    miss_valid = 1'b1;
    miss_addr  = 10'h2AA;
    start_replay();
    miss_valid = 1'b0;
    check("t6_busy",    32'(b_busy), 1);
    check("t6_b_count", 32'(b_count), 1);
    step();
    check("t6_addr",  32'(b_out_addr), 10'h2AA);
    check("t6_valid", 32'(a_out_valid), 1);
    step();
    check("t6_end_valid", 32'(b_out_valid), 0);
    check("t6_end_busy",  32'(b_busy), 0);
    check("t6_b_count0",  32'(b_count), 0);
    check("t6_a_count1",  32'(a_count), 1);
    do_clear();

    // Reset asserted while the second entry is on the output.
    push(10'h0A1); push(10'h0A2); push(10'h0A3);
    start_replay();
    step();
    step();
    check("t7_addr1", 32'(a_out_addr), 10'h0A2);
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(a_out_valid), 0);
    check("t7_rst_count", 32'(a_count), 0);
    check("t7_rst_busy",  32'(a_busy), 0);
    check("t7_rst_ready", 32'(a_miss_ready), 1);
    check("t7_rst_addr",  32'(a_out_addr), 0);
    check("t7_rst_b_valid", 32'(b_out_valid), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t7_post_valid", 32'(a_out_valid | b_out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
